// File: rtl/vga_timing_gen.sv
// Raster timing generator and pixel output stage: counters, aligned sync/DE/frame-start and blanked RGB565 output.
// Optional macro VGA_TEST_PATTERN_EN replaces active video with eight vertical colour bars.
module vga_timing_gen #(
    parameter int H_ACT    = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACT    = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int SYNC_POL = 1,
    parameter int PIX_LAT  = 1
) (
    input  logic        clk_vga,
    input  logic        rst_n_vga,
    input  logic [15:0] pixel_data,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [15:0] rgb,
    output logic        frame_start
);

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOT - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOT - 1);
    localparam logic [11:0] H_ACT_C  = 12'(H_ACT);
    localparam logic [11:0] V_ACT_C  = 12'(V_ACT);
    localparam logic [11:0] HS_BEG   = 12'(H_ACT + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACT + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_BEG   = 12'(V_ACT + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACT + V_FP + V_SYNC - 1);
    localparam logic        SYNC_ACT = (SYNC_POL != 0);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_wrap;

    assign h_wrap = (h_cnt == H_LAST);

    always_ff @(posedge clk_vga or negedge rst_n_vga) begin
        if (!rst_n_vga) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 12'd1;
            end
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    assign xpos = h_cnt;
    assign ypos = v_cnt;

    // Raw control bits, active-true encoding: {de, hs, vs, fs}
    logic de_r;
    logic hs_r;
    logic vs_r;
    logic fs_r;
    logic [3:0] ctl_raw;

    always_comb begin
        de_r    = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs_r    = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
        vs_r    = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
        fs_r    = (h_cnt == 12'd0) && (v_cnt == 12'd0);
        ctl_raw = {de_r, hs_r, vs_r, fs_r};
    end

    // Delay line matching the renderer latency; clears to all-inactive so no partial sync leaks out of reset
    logic [3:0] ctl_sr [PIX_LAT];

    always_ff @(posedge clk_vga or negedge rst_n_vga) begin
        if (!rst_n_vga) begin
            for (int i = 0; i < PIX_LAT; i++) begin
                ctl_sr[i] <= '0;
            end
        end else begin
            ctl_sr[0] <= ctl_raw;
            for (int i = 1; i < PIX_LAT; i++) begin
                ctl_sr[i] <= ctl_sr[i-1];
            end
        end
    end

    logic de_d;
    logic hs_d;
    logic vs_d;
    logic fs_d;

    assign {de_d, hs_d, vs_d, fs_d} = ctl_sr[PIX_LAT-1];

    logic [15:0] colour_d;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [11:0] BAR_W = 12'(H_ACT / 8);

    logic [2:0] bar_raw;
    logic [2:0] bar_sr [PIX_LAT];

    assign bar_raw = 3'(h_cnt / BAR_W);

    always_ff @(posedge clk_vga or negedge rst_n_vga) begin
        if (!rst_n_vga) begin
            for (int i = 0; i < PIX_LAT; i++) begin
                bar_sr[i] <= '0;
            end
        end else begin
            bar_sr[0] <= bar_raw;
            for (int i = 1; i < PIX_LAT; i++) begin
                bar_sr[i] <= bar_sr[i-1];
            end
        end
    end

    always_comb begin
        colour_d = 16'h0000;
        case (bar_sr[PIX_LAT-1])
            3'd0:    colour_d = 16'hFFFF;
            3'd1:    colour_d = 16'hFFE0;
            3'd2:    colour_d = 16'h07FF;
            3'd3:    colour_d = 16'h07E0;
            3'd4:    colour_d = 16'hF81F;
            3'd5:    colour_d = 16'hF800;
            3'd6:    colour_d = 16'h001F;
            default: colour_d = 16'h0000;
        endcase
    end
`else
    assign colour_d = pixel_data;
`endif

    always_ff @(posedge clk_vga or negedge rst_n_vga) begin
        if (!rst_n_vga) begin
            rgb         <= 16'h0000;
            de          <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
        end else begin
            rgb         <= de_d ? colour_d : 16'h0000;
            de          <= de_d;
            frame_start <= fs_d;
            hsync       <= hs_d ? SYNC_ACT : ~SYNC_ACT;
            vsync       <= vs_d ? SYNC_ACT : ~SYNC_ACT;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster; two instances cover PIX_LAT=1/active-high and PIX_LAT=3/active-low.
// Honours VGA_TEST_PATTERN_EN in its reference model.
module tb_vga_timing_gen;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk_vga = 1'b0;
    logic rst_n_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    logic [15:0] pd1 = 16'hFFFF;
    logic [15:0] pd3 = 16'hFFFF;
    logic [11:0] x1, y1, x3, y3;
    logic        hs1, vs1, de1, fs1, hs3, vs3, de3, fs3;
    logic [15:0] rgb1, rgb3;

    vga_timing_gen #(
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1), .PIX_LAT(1)
    ) dut1 (
        .clk_vga(clk_vga), .rst_n_vga(rst_n_vga), .pixel_data(pd1),
        .xpos(x1), .ypos(y1), .hsync(hs1), .vsync(vs1), .de(de1),
        .rgb(rgb1), .frame_start(fs1)
    );

    vga_timing_gen #(
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0), .PIX_LAT(3)
    ) dut3 (
        .clk_vga(clk_vga), .rst_n_vga(rst_n_vga), .pixel_data(pd3),
        .xpos(x3), .ypos(y3), .hsync(hs3), .vsync(vs3), .de(de3),
        .rgb(rgb3), .frame_start(fs3)
    );

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] rgb;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    int checks = 0;
    int errors = 0;
    int n = 0;
    int last_fs = -1;
    int first_fs = -1;

    // Colour the renderer would return for cycle index k; blanking returns all-ones to prove masking
    function automatic logic [15:0] pix(int k);
        int h;
        int v;
        logic [11:0] hh;
        logic [3:0] vv;
        if (k < 0) return 16'hFFFF;
        h = k % HT;
        v = (k / HT) % VT;
        hh = 12'(h);
        vv = 4'(v);
        if (h < HA && v < VA) return {vv, hh};
        return 16'hFFFF;
    endfunction

    function automatic exp_t model(int k, logic pol);
        exp_t e;
        int h;
        int v;
        h = k % HT;
        v = (k / HT) % VT;
        e.de = (h < HA) && (v < VA);
        e.hs = (h >= HA + HF && h < HA + HF + HS) ? pol : ~pol;
        e.vs = (v >= VA + VF && v < VA + VF + VS) ? pol : ~pol;
        e.fs = (h == 0) && (v == 0);
`ifdef VGA_TEST_PATTERN_EN
        case (h / (HA / 8))
            0:       e.rgb = 16'hFFFF;
            1:       e.rgb = 16'hFFE0;
            2:       e.rgb = 16'h07FF;
            3:       e.rgb = 16'h07E0;
            4:       e.rgb = 16'hF81F;
            5:       e.rgb = 16'hF800;
            6:       e.rgb = 16'h001F;
            default: e.rgb = 16'h0000;
        endcase
`else
        e.rgb = pix(k);
`endif
        if (!e.de) e.rgb = 16'h0000;
        return e;
    endfunction

    function automatic exp_t idle(logic pol);
        exp_t e;
        e.de  = 1'b0;
        e.hs  = ~pol;
        e.vs  = ~pol;
        e.fs  = 1'b0;
        e.rgb = 16'h0000;
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, expv);
        end
    endtask

    task automatic start_model();
        n = 0;
        q1.delete();
        q3.delete();
        repeat (2) q1.push_back(idle(1'b1));
        repeat (4) q3.push_back(idle(1'b0));
    endtask

    // One cycle: compare at the current (negedge) point, drive the next pixel, then advance
    task automatic step();
        exp_t e;
        check("xpos1", 16'(x1), 16'(n % HT));
        check("ypos1", 16'(y1), 16'((n / HT) % VT));
        check("xpos3", 16'(x3), 16'(n % HT));
        check("ypos3", 16'(y3), 16'((n / HT) % VT));
        pd1 = pix(n - 1);
        pd3 = pix(n - 3);
        q1.push_back(model(n, 1'b1));
        q3.push_back(model(n, 1'b0));
        e = q1.pop_front();
        check("de1", 16'(de1), 16'(e.de));
        check("hsync1", 16'(hs1), 16'(e.hs));
        check("vsync1", 16'(vs1), 16'(e.vs));
        check("fs1", 16'(fs1), 16'(e.fs));
        check("rgb1", rgb1, e.rgb);
        e = q3.pop_front();
        check("de3", 16'(de3), 16'(e.de));
        check("hsync3", 16'(hs3), 16'(e.hs));
        check("vsync3", 16'(vs3), 16'(e.vs));
        check("fs3", 16'(fs3), 16'(e.fs));
        check("rgb3", rgb3, e.rgb);
        if (fs1) begin
            if (first_fs < 0) first_fs = n;
            if (last_fs >= 0) check("fs_period", 16'(n - last_fs), 16'(FRAME));
            last_fs = n;
        end
        @(negedge clk_vga);
        n++;
    endtask

    initial begin
        repeat (3) @(negedge clk_vga);
        check("rst_xpos", 16'(x1), 16'd0);
        check("rst_ypos", 16'(y1), 16'd0);
        check("rst_de", 16'(de1), 16'd0);
        check("rst_hsync1", 16'(hs1), 16'd0);
        check("rst_vsync1", 16'(vs1), 16'd0);
        check("rst_hsync3", 16'(hs3), 16'd1);
        check("rst_rgb", rgb1, 16'h0000);

        rst_n_vga = 1'b1;
        start_model();
        repeat (2 * FRAME + 3 * HT + 10) step();
        check("first_fs", 16'(first_fs), 16'd2);

        // Mid-line reset: outputs must drop before any clock edge
        #1 rst_n_vga = 1'b0;
        #1;
        check("midrst_rgb1", rgb1, 16'h0000);
        check("midrst_de1", 16'(de1), 16'd0);
        check("midrst_de3", 16'(de3), 16'd0);
        check("midrst_xpos", 16'(x1), 16'd0);
        check("midrst_ypos", 16'(y1), 16'd0);
        check("midrst_hsync3", 16'(hs3), 16'd1);
        repeat (3) @(negedge clk_vga);
        check("midrst_hold_de", 16'(de1), 16'd0);

        rst_n_vga = 1'b1;
        first_fs = -1;
        last_fs = -1;
        start_model();
        repeat (FRAME + 40) step();
        check("first_fs_after_rst", 16'(first_fs), 16'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
